// File: rtl/mem_arbiter.sv
// Arbitrates NPORT request ports onto a single word-addressed memory with fixed read latency.
// One transaction in flight; round-robin or fixed-priority grant selection.
module mem_arbiter #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 1,
    parameter int unsigned PRIO  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT-1:0]    req_valid,
    input  logic [NPORT-1:0]    req_we,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT*DW-1:0] req_wdata,
    output logic [NPORT-1:0]    req_ready,
    output logic [NPORT-1:0]    rsp_valid,
    output logic                rsp_err,
    output logic [DW-1:0]       rsp_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int unsigned LW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam int unsigned XW = AW + 32;

    typedef enum logic [1:0] {StIdle, StAccess, StWaiting, StResp} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   port_q, port_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            found;
    logic [LW-1:0]   win;
    logic [AW-1:0]   word_idx;
    logic            in_range;

    // i-th candidate in search order: rotated past the last grant, or plain index order.
    function automatic logic [LW-1:0] cand(input int unsigned i, input logic [LW-1:0] last);
        int unsigned p;
        if (PRIO != 0) p = i;
        else           p = (32'(last) + 32'd1 + i) % NPORT;
        return LW'(p);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (!found && req_valid[cand(i, last_grant_q)]) begin
                found = 1'b1;
                win   = cand(i, last_grant_q);
            end
        end
    end

    assign word_idx = addr_q >> 2;
    // Widened compare so a DEPTH beyond the address range never truncates.
    assign in_range = XW'(word_idx) < XW'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= LW'(NPORT - 1);
            cnt_q        <= '0;
            port_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_err      = 1'b0;
        rsp_rdata    = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        // Outputs are forced low for the whole reset cycle, which also aborts any transaction.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        req_ready[win] = 1'b1;
                        port_d         = win;
                        we_d           = req_we[win];
                        addr_d         = req_addr[32'(win) * AW +: AW];
                        wdata_d        = req_wdata[32'(win) * DW +: DW];
                        last_grant_d   = win;
                        state_d        = StAccess;
                    end
                end
                StAccess: begin
                    mem_en    = in_range;
                    mem_we    = in_range & we_q;
                    mem_addr  = word_idx;
                    mem_wdata = wdata_q;
                    if (WAIT > 1) begin
                        cnt_d   = CW'(WAIT - 1);
                        state_d = StWaiting;
                    end else begin
                        state_d = StResp;
                    end
                end
                StWaiting: begin
                    if (cnt_q <= CW'(1)) state_d = StResp;
                    if (cnt_q != '0)     cnt_d   = cnt_q - CW'(1);
                end
                StResp: begin
                    rsp_valid[port_q] = 1'b1;
                    rsp_err           = !in_range;
                    rsp_rdata         = (in_range && !we_q) ? mem_rdata : '0;
                    state_d           = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (round-robin, fixed priority, WAIT=3)
// with a latency-accurate memory model; stimulus queues expectations, a monitor checks them.
module tb_mem_arbiter;

    typedef struct {
        int          d;
        int          port;
        bit          en;
        bit          we;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          d;
        int          port;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk;
    logic rst;

    logic [2:0][1:0]  rv;
    logic [2:0][1:0]  rwe;
    logic [2:0][63:0] raddr;
    logic [2:0][63:0] rwd;
    logic [2:0][1:0]  rdy;
    logic [2:0][1:0]  rsv;
    logic [2:0]       rerr;
    logic [2:0][31:0] rdat;
    logic [2:0]       me;
    logic [2:0]       mwe;
    logic [2:0][31:0] ma;
    logic [2:0][31:0] mwd;
    logic [2:0][31:0] mrd;

    logic [31:0] mem [3][64];
    logic [31:0] st  [3][3];

    grant_t exp_g[$];
    rsp_t   exp_r[$];
    int     gcyc[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     waits[3] = '{1, 1, 3};
    bit     busy[3];
    bit     pend[3];
    int     acc_cyc[3];
    grant_t cur[3];

    mem_arbiter #(.NPORT(2), .AW(32), .DW(32), .DEPTH(64), .WAIT(1), .PRIO(0)) u_rr (
        .clk(clk), .reset(rst), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(raddr[0]),
        .req_wdata(rwd[0]), .req_ready(rdy[0]), .rsp_valid(rsv[0]), .rsp_err(rerr[0]),
        .rsp_rdata(rdat[0]), .mem_en(me[0]), .mem_we(mwe[0]), .mem_addr(ma[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    mem_arbiter #(.NPORT(2), .AW(32), .DW(32), .DEPTH(64), .WAIT(1), .PRIO(1)) u_fp (
        .clk(clk), .reset(rst), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(raddr[1]),
        .req_wdata(rwd[1]), .req_ready(rdy[1]), .rsp_valid(rsv[1]), .rsp_err(rerr[1]),
        .rsp_rdata(rdat[1]), .mem_en(me[1]), .mem_we(mwe[1]), .mem_addr(ma[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    mem_arbiter #(.NPORT(2), .AW(32), .DW(32), .DEPTH(64), .WAIT(3), .PRIO(0)) u_w3 (
        .clk(clk), .reset(rst), .req_valid(rv[2]), .req_we(rwe[2]), .req_addr(raddr[2]),
        .req_wdata(rwd[2]), .req_ready(rdy[2]), .rsp_valid(rsv[2]), .rsp_err(rerr[2]),
        .rsp_rdata(rdat[2]), .mem_en(me[2]), .mem_we(mwe[2]), .mem_addr(ma[2]),
        .mem_wdata(mwd[2]), .mem_rdata(mrd[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: preload C0DE0000|index, word 4 = DEADBEEF; read data is valid for one cycle only.
    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 64; a++) mem[d][a] <= 32'hC0DE_0000 | 32'(a);
            mem[d][4] <= 32'hDEAD_BEEF;
            for (int k = 0; k < 3; k++) st[d][k] <= 32'h0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            st[d][0] <= (me[d] && !mwe[d]) ? mem[d][ma[d][5:0]] : 32'h0;
            st[d][1] <= st[d][0];
            st[d][2] <= st[d][1];
            if (me[d] && mwe[d]) mem[d][ma[d][5:0]] <= mwd[d];
        end
    end

    assign mrd[0] = st[0][0];
    assign mrd[1] = st[1][0];
    assign mrd[2] = st[2][2];

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        grant_t g;
        rsp_t   r;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    chk(rdy[d] == 0 && rsv[d] == 0 && !rerr[d] && rdat[d] == 0 && !me[d] &&
                        !mwe[d] && ma[d] == 0 && mwd[d] == 0, "reset_outputs",
                        64'({rdy[d], rsv[d], rerr[d], me[d], mwe[d]}), 64'(0));
                    busy[d] = 1'b0;
                    pend[d] = 1'b0;
                end else begin
                    if (rdy[d] != 0) begin
                        chk(!busy[d] && $onehot(rdy[d]), "ready_only_when_idle",
                            64'({busy[d], rdy[d]}), 64'(1));
                        if (exp_g.size() == 0) begin
                            chk(1'b0, "grant_unexpected", 64'(rdy[d]), 64'(0));
                        end else begin
                            g = exp_g.pop_front();
                            chk(g.d == d && rdy[d] == (2'b01 << g.port), "grant_port",
                                64'(rdy[d]), 64'(2'b01 << g.port));
                            cur[d] = g;
                        end
                        busy[d]    = 1'b1;
                        pend[d]    = 1'b1;
                        acc_cyc[d] = cyc;
                        gcyc.push_back(cyc);
                    end else if (pend[d] && cyc == acc_cyc[d] + 1) begin
                        chk(me[d] == cur[d].en, "mem_en", 64'(me[d]), 64'(cur[d].en));
                        if (cur[d].en)
                            chk(mwe[d] == cur[d].we && ma[d] == cur[d].waddr &&
                                mwd[d] == cur[d].wdata, "mem_cmd",
                                {31'(0), mwe[d], ma[d]}, {31'(0), cur[d].we, cur[d].waddr});
                        pend[d] = 1'b0;
                    end else if (me[d]) begin
                        chk(1'b0, "mem_en_stray", 64'(1), 64'(0));
                    end
                    if (rsv[d] != 0) begin
                        if (exp_r.size() == 0) begin
                            chk(1'b0, "rsp_unexpected", 64'(rsv[d]), 64'(0));
                        end else begin
                            r = exp_r.pop_front();
                            chk(r.d == d && rsv[d] == (2'b01 << r.port), "rsp_port",
                                64'(rsv[d]), 64'(2'b01 << r.port));
                            chk(rerr[d] == r.err && rdat[d] == r.rdata, "rsp_data",
                                {31'(0), rerr[d], rdat[d]}, {31'(0), r.err, r.rdata});
                            chk(cyc == acc_cyc[d] + 1 + waits[d], "rsp_latency",
                                64'(cyc - acc_cyc[d]), 64'(1 + waits[d]));
                        end
                        busy[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input int p, input bit v, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        rv[d][p]             = v;
        rwe[d][p]            = we;
        raddr[d][p*32 +: 32] = addr;
        rwd[d][p*32 +: 32]   = wdata;
    endtask

    task automatic expect_txn(input int d, input int p, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit err,
                              input logic [31:0] rdata, input bit want_rsp);
        grant_t g;
        rsp_t   r;
        g = '{d: d, port: p, en: !err, we: we, waddr: addr >> 2, wdata: wdata};
        exp_g.push_back(g);
        if (want_rsp) begin
            r = '{d: d, port: p, err: err, rdata: rdata};
            exp_r.push_back(r);
        end
    endtask

    task automatic wait_grants(input int d, input int n, input logic [1:0] pm);
        int seen = 0;
        for (int i = 0; i < 60 && seen < n; i++) begin
            @(negedge clk);
            if ((rdy[d] & pm) != 0) seen++;
        end
        if (seen < n) chk(1'b0, "grant_timeout", 64'(seen), 64'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int d, input int p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit err, input logic [31:0] rdata);
        expect_txn(d, p, we, addr, wdata, err, rdata, 1'b1);
        drive(d, p, 1'b1, we, addr, wdata);
        wait_grants(d, 1, 2'b01 << p);
        drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        rv    = '0;
        rwe   = '0;
        raddr = '0;
        rwd   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single transactions, boundary addresses and out-of-range on the round-robin instance.
        single(0, 0, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF);
        single(0, 1, 1'b1, 32'h20,  32'h1234_5678, 1'b0, 32'h0);
        single(0, 0, 1'b0, 32'h23,  32'h0,         1'b0, 32'h1234_5678);
        single(0, 1, 1'b1, 32'h100, 32'h55,        1'b1, 32'h0);
        single(0, 0, 1'b0, 32'hFC,  32'h0,         1'b0, 32'hC0DE_003F);
        single(0, 1, 1'b0, 32'h104, 32'h0,         1'b1, 32'h0);

        // Fresh reset, then continuous contention: 0,1,0,1 three cycles apart.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        gcyc.delete();
        for (int k = 0; k < 2; k++) begin
            expect_txn(0, 0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
            expect_txn(0, 1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hC0DE_0005, 1'b1);
        end
        drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(0, 1, 1'b1, 1'b0, 32'h14, 32'h0);
        wait_grants(0, 4, 2'b11);
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk(gcyc.size() == 4, "rr_grant_count", 64'(gcyc.size()), 64'(4));
        for (int k = 0; k + 1 < gcyc.size(); k++)
            chk(gcyc[k+1] - gcyc[k] == 3, "rr_spacing", 64'(gcyc[k+1] - gcyc[k]), 64'(3));

        // Reset in the cycle after mem_en aborts the read; port 0 then wins despite last grant 0.
        expect_txn(0, 0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_txn(0, 0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        expect_txn(0, 1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hC0DE_0005, 1'b1);
        drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_grants(0, 1, 2'b01);
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(0, 1, 1'b1, 1'b0, 32'h14, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_grants(0, 2, 2'b11);
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        // Fixed priority: port 0 takes every grant until it drops.
        for (int k = 0; k < 3; k++)
            expect_txn(1, 0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        expect_txn(1, 1, 1'b0, 32'h14, 32'h0, 1'b0, 32'hC0DE_0005, 1'b1);
        drive(1, 0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1, 1'b1, 1'b0, 32'h14, 32'h0);
        wait_grants(1, 3, 2'b11);
        drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_grants(1, 1, 2'b10);
        drive(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        // WAIT=3: port 1 stays blocked for the whole read, then a write and read-back.
        expect_txn(2, 0, 1'b0, 32'h18, 32'h0,         1'b0, 32'hC0DE_0006, 1'b1);
        expect_txn(2, 1, 1'b1, 32'h30, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b1);
        drive(2, 0, 1'b1, 1'b0, 32'h18, 32'h0);
        drive(2, 1, 1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5);
        wait_grants(2, 2, 2'b11);
        drive(2, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        single(2, 1, 1'b0, 32'h30, 32'h0, 1'b0, 32'hA5A5_A5A5);

        repeat (4) @(posedge clk);
        #1;
        chk(exp_g.size() == 0, "grants_outstanding", 64'(exp_g.size()), 64'(0));
        chk(exp_r.size() == 0, "rsps_outstanding", 64'(exp_r.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
